// File: rtl/stream_tap_arbiter.sv
// Round-robin arbiter that merges per-requester tap beats into one AXI-Stream packet stream.
// Optional header beat per packet is enabled by defining STREAM_TAP_ARBITER_HEADER_EN.
module stream_tap_arbiter #(
  parameter int DATA_WIDTH        = 128,
  parameter int NUM_REQ           = 4,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter logic [NUM_REQ*STREAM_TYPE_WIDTH-1:0] STREAM_TYPES = '0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_in_progress,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          busy,
  output logic [2:0]                    grant_idx,
  output logic [31:0]                   pkt_count
);
  localparam int IDX_W = 3;

`ifdef STREAM_TAP_ARBITER_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, XFER = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd2} state_t;
`endif

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [31:0]             pkt_count_q, pkt_count_d;

  logic [IDX_W-1:0]        rr_winner;
  logic                    rr_found;
  logic                    sel_valid;
  logic                    sel_inprog;
  logic [DATA_WIDTH-1:0]   sel_data;

  // First valid requester scanning upward from the one after the last grant.
  always_comb begin
    rr_winner = last_q;
    rr_found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rr_found && req_valid[i] &&
            IDX_W'(i) == IDX_W'((int'(last_q) + 1 + k) % NUM_REQ)) begin
          rr_winner = IDX_W'(i);
          rr_found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_valid  = 1'b0;
    sel_inprog = 1'b0;
    sel_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_valid  = req_valid[i];
        sel_inprog = req_in_progress[i];
        sel_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef STREAM_TAP_ARBITER_HEADER_EN
  logic [STREAM_TYPE_WIDTH-1:0] sel_type;
  logic [DATA_WIDTH-1:0]        hdr_data;

  always_comb begin
    sel_type = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) sel_type = STREAM_TYPES[i*STREAM_TYPE_WIDTH +: STREAM_TYPE_WIDTH];
    end
    hdr_data                          = '0;
    hdr_data[STREAM_TYPE_WIDTH-1:0]   = sel_type;
    hdr_data[10:8]                    = grant_q;
    hdr_data[31:16]                   = pkt_count_q[15:0];
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^STREAM_TYPES;
`endif

  // Stream outputs follow the granted requester combinationally; IDLE drives all zeros.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    req_ready     = '0;
    case (state_q)
`ifdef STREAM_TAP_ARBITER_HEADER_EN
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_data;
      end
`endif
      XFER: begin
        m_axis_tvalid = sel_valid;
        m_axis_tlast  = sel_valid & ~sel_inprog;
        m_axis_tdata  = sel_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant_q == IDX_W'(i)) & m_axis_tready;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_winner;
`ifdef STREAM_TAP_ARBITER_HEADER_EN
          state_d = HDR;
`else
          state_d = XFER;
`endif
        end
      end
`ifdef STREAM_TAP_ARBITER_HEADER_EN
      HDR: begin
        if (m_axis_tready) state_d = XFER;
      end
`endif
      XFER: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_d     = IDLE;
          pkt_count_d = pkt_count_q + 32'd1;
          last_d      = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_idx = grant_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_stream_tap_arbiter.sv
// Directed bench for stream_tap_arbiter: 4 requesters, 32-bit data, hand-computed expectations.
// The header scenario runs only when STREAM_TAP_ARBITER_HEADER_EN is defined.
module tb_stream_tap_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TW = 3;

  logic            clk;
  logic            resetn;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_in_progress;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tready;
  logic            busy;
  logic [2:0]      grant_idx;
  logic [31:0]     pkt_count;

  int checks = 0;
  int errors = 0;

  stream_tap_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .STREAM_TYPE_WIDTH(TW),
    .STREAM_TYPES(12'h028)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_in_progress(req_in_progress), .req_data(req_data),
    .req_ready(req_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .busy(busy), .grant_idx(grant_idx), .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end else begin
      $display("ok   %s = %0h", tag, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  int b;
  logic acc;

  initial begin
    resetn = 1'b0;
    req_valid = '0; req_in_progress = '0; req_data = '0; m_axis_tready = 1'b0;
    #1;
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant", grant_idx, 0);
    check_eq("rst_pkt", pkt_count, 0);
    check_eq("rst_ready", req_ready, 0);
    step(); step();
    resetn = 1'b1;
    step();

    // Requester 0, three beats, continuous ready.
    req_valid = 4'b0001; req_in_progress = 4'b0001; set_data(0, 32'hA1); m_axis_tready = 1'b1;
    #1;
    check_eq("t1_idle_tvalid", m_axis_tvalid, 0);
    step();
    check_eq("t1_b1_tvalid", m_axis_tvalid, 1);
    check_eq("t1_b1_data", m_axis_tdata, 32'hA1);
    check_eq("t1_b1_tlast", m_axis_tlast, 0);
    check_eq("t1_b1_ready", req_ready, 4'b0001);
    step();
    set_data(0, 32'hA2); #1;
    check_eq("t1_b2_data", m_axis_tdata, 32'hA2);
    check_eq("t1_b2_tlast", m_axis_tlast, 0);
    step();
    set_data(0, 32'hA3); req_in_progress = 4'b0000; #1;
    check_eq("t1_b3_data", m_axis_tdata, 32'hA3);
    check_eq("t1_b3_tlast", m_axis_tlast, 1);
    step();
    req_valid = '0; #1;
    check_eq("t1_end_tvalid", m_axis_tvalid, 0);
    check_eq("t1_end_busy", busy, 0);
    check_eq("t1_end_pkt", pkt_count, 1);

    // All four requesting single-beat packets: 0,1,2,3,0 with an IDLE between.
    do_reset();
    for (int i = 0; i < NR; i++) set_data(i, 32'h100 + i);
    req_valid = 4'b1111; req_in_progress = '0; m_axis_tready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      step();
      check_eq($sformatf("t2_p%0d_grant", p), grant_idx, p % 4);
      check_eq($sformatf("t2_p%0d_data", p), m_axis_tdata, 32'h100 + (p % 4));
      check_eq($sformatf("t2_p%0d_tlast", p), m_axis_tlast, 1);
      check_eq($sformatf("t2_p%0d_ready", p), req_ready, 4'b0001 << (p % 4));
      step();
      if (p == 4) req_valid = '0;
      check_eq($sformatf("t2_p%0d_gap_tvalid", p), m_axis_tvalid, 0);
      check_eq($sformatf("t2_p%0d_gap_busy", p), busy, 0);
    end

    // Requester 3, four beats, ready toggling 1,0,1,0...
    req_valid = 4'b1000; req_in_progress = 4'b1000; set_data(3, 32'hD0);
    step();
    b = 0;
    for (int c = 0; c < 20 && b < 4; c++) begin
      m_axis_tready = (c % 2 == 0);
      set_data(3, 32'hD0 + b);
      req_in_progress = (b < 3) ? 4'b1000 : 4'b0000;
      #1;
      check_eq($sformatf("t3_c%0d_data", c), m_axis_tdata, 32'hD0 + b);
      check_eq($sformatf("t3_c%0d_ready", c), req_ready, m_axis_tready ? 4'b1000 : 4'b0000);
      check_eq($sformatf("t3_c%0d_tlast", c), m_axis_tlast, (b == 3));
      acc = m_axis_tready;
      step();
      if (acc) b++;
    end
    check_eq("t3_beats", b, 4);
    req_valid = '0; m_axis_tready = 1'b1; #1;
    check_eq("t3_end_pkt", pkt_count, 6);
    check_eq("t3_end_busy", busy, 0);

    // Requester 1 stalls mid-packet while requester 2 waits.
    req_valid = 4'b0110; req_in_progress = 4'b0010;
    set_data(1, 32'hE0); set_data(2, 32'h2222);
    step();
    check_eq("t4_grant", grant_idx, 1);
    check_eq("t4_b0_data", m_axis_tdata, 32'hE0);
    check_eq("t4_b0_tlast", m_axis_tlast, 0);
    step();
    req_valid = 4'b0100; #1;
    check_eq("t4_bub1_tvalid", m_axis_tvalid, 0);
    check_eq("t4_bub1_ready", req_ready, 4'b0010);
    step();
    check_eq("t4_bub2_tvalid", m_axis_tvalid, 0);
    check_eq("t4_bub2_grant", grant_idx, 1);
    step();
    req_valid = 4'b0110; set_data(1, 32'hE1); #1;
    check_eq("t4_b1_data", m_axis_tdata, 32'hE1);
    check_eq("t4_b1_tlast", m_axis_tlast, 0);
    step();
    set_data(1, 32'hE2); req_in_progress = 4'b0000; #1;
    check_eq("t4_b2_tlast", m_axis_tlast, 1);
    step();
    check_eq("t4_end_busy", busy, 0);
    check_eq("t4_end_pkt", pkt_count, 7);
    req_valid = 4'b0100;
    step();
    check_eq("t4_next_grant", grant_idx, 2);
    check_eq("t4_next_data", m_axis_tdata, 32'h2222);
    step();
    req_valid = '0; #1;
    check_eq("t4_req2_pkt", pkt_count, 8);

    // Reset mid-packet of requester 3.
    req_valid = 4'b1000; req_in_progress = 4'b1000; set_data(3, 32'h33); set_data(0, 32'h77);
    step();
    check_eq("t5_pre_tvalid", m_axis_tvalid, 1);
    #1;
    resetn = 1'b0; #1;
    check_eq("t5_rst_tvalid", m_axis_tvalid, 0);
    check_eq("t5_rst_ready", req_ready, 0);
    check_eq("t5_rst_tlast", m_axis_tlast, 0);
    check_eq("t5_rst_tdata", m_axis_tdata, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_pkt", pkt_count, 0);
    check_eq("t5_rst_grant", grant_idx, 0);
    step();
    resetn = 1'b1; req_valid = 4'b1001; req_in_progress = 4'b0000;
    step();
    check_eq("t5_after_grant", grant_idx, 0);
    check_eq("t5_after_data", m_axis_tdata, 32'h77);
    step();
    req_valid = '0; #1;
    check_eq("t5_after_pkt", pkt_count, 1);

`ifdef STREAM_TAP_ARBITER_HEADER_EN
    // Header build: requester 1, type code 5, header carries the running packet count.
    do_reset();
    set_data(1, 32'hF0); req_in_progress = '0; m_axis_tready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      req_valid = 4'b0010;
      step();
      check_eq($sformatf("h_n%0d_hdr", n), m_axis_tdata, (n << 16) | 32'h105);
      check_eq($sformatf("h_n%0d_hdr_tlast", n), m_axis_tlast, 0);
      check_eq($sformatf("h_n%0d_hdr_ready", n), req_ready, 0);
      step();
      check_eq($sformatf("h_n%0d_data", n), m_axis_tdata, 32'hF0);
      check_eq($sformatf("h_n%0d_tlast", n), m_axis_tlast, 1);
      req_valid = '0;
      step();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
